// File: rtl/audio_bus_pkg.sv
// Shared widths and frame type for the multi-channel audio bus.
package audio_bus_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_CH_DEF     = 2;
  localparam int DEPTH_DEF      = 4;

  // Channel index width; a single-channel bus still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointers carry one extra bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W_DEF = $clog2(DEPTH_DEF) + 1;
  localparam int LVL_W_DEF = $clog2(DEPTH_DEF + 1);

  typedef logic [NUM_CH_DEF-1:0][DATA_WIDTH_DEF-1:0] frame_t;

endpackage

// File: rtl/audio_bus_mc_fifo.sv
// Frame FIFO with registered head output and registered level counter.
module audio_frame_fifo
  import audio_bus_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      push_ok,
  output logic [WIDTH-1:0]          head,
  output logic                      head_vld,
  input  logic                      pop_rdy,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr, rptr_n;
  logic [WIDTH-1:0] head_n;
  logic [LW-1:0]    level_n;
  logic             full, pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = head_vld && pop_rdy;
  assign push_ok = push && (!full || pop);
  assign rptr_n  = rptr + PW'(pop);
  assign level_n = level + LW'(push_ok) - LW'(pop);

  // The head register is loaded with whatever sits at the post-edge read
  // pointer; a frame written into that very slot bypasses the array.
  always_comb begin
    head_n = mem[rptr_n[AW-1:0]];
    if (push_ok && (wptr[AW-1:0] == rptr_n[AW-1:0])) head_n = wdata;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      head     <= '0;
      head_vld <= 1'b0;
    end else begin
      wptr     <= wptr + PW'(push_ok);
      rptr     <= rptr_n;
      level    <= level_n;
      head     <= head_n;
      head_vld <= (level_n != '0);
    end
  end

endmodule

// File: rtl/audio_bus_mc.sv
// Multi-channel audio bus: assembles per-channel samples into frames and
// buffers them for a valid/ready consumer. Optional: AUDIO_BUS_SYNC_EN.
module audio_bus_mc
  import audio_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         newin,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         sof,
  output logic                         rinc,
  output logic                         o_clk,
  output logic                         o_rst,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic                         dvalid,
  input  logic                         dready,
  output logic [lvl_w(DEPTH)-1:0]      level,
  output logic                         ovf
);

  localparam int CW = idx_w(NUM_CH);

  logic [CW-1:0]                        ch, ch_n, slot;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    asm_q, frame;
  logic                                 push, push_ok, frame_err;

  assign rinc  = newin;
  assign o_clk = i_clk;
  assign o_rst = i_rst;

  always_comb begin
    slot      = ch;
    frame_err = 1'b0;
`ifdef AUDIO_BUS_SYNC_EN
    // A start-of-frame mark realigns to slot 0; anything half-built is lost.
    if (newin && sof) begin
      slot      = '0;
      frame_err = (ch != '0);
    end
`endif
    push = newin && (slot == CW'(NUM_CH - 1));
    ch_n = ch;
    if (newin) ch_n = push ? '0 : slot + CW'(1);
  end

`ifndef AUDIO_BUS_SYNC_EN
  logic unused_sof;
  assign unused_sof = sof;
`endif

  // The outgoing frame includes the sample arriving on the completing edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign frame[k] = (newin && (slot == CW'(k))) ? din : asm_q[k];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ch    <= '0;
      asm_q <= '0;
      ovf   <= 1'b0;
    end else begin
      ch <= ch_n;
      if (newin) asm_q <= frame;
      if (frame_err || (push && !push_ok)) ovf <= 1'b1;
    end
  end

  audio_frame_fifo #(
    .WIDTH (NUM_CH * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .push     (push),
    .wdata    (frame),
    .push_ok  (push_ok),
    .head     (dout),
    .head_vld (dvalid),
    .pop_rdy  (dready),
    .level    (level)
  );

endmodule

// File: tb/tb_audio_bus_mc.sv
// Directed bench for audio_bus_mc with a frame scoreboard and level/ovf model.
module tb_audio_bus_mc;

  localparam int DW     = 32;
  localparam int NCH    = 2;
  localparam int DEPTH  = 4;

  typedef logic [NCH-1:0][DW-1:0] frm_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              newin = 1'b0;
  logic [DW-1:0]     din   = '0;
  logic              sof   = 1'b0;
  logic              dready = 1'b0;
  logic              rinc, o_clk, o_rst, dvalid, ovf;
  logic [NCH*DW-1:0] dout;
  logic [2:0]        level;

  int   errors = 0;
  int   checks = 0;
  frm_t q[$];
  int   mlev = 0;
  int   mch  = 0;
  logic movf = 1'b0;
  frm_t masm = '0;

  audio_bus_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .newin(newin), .din(din), .sof(sof),
    .rinc(rinc), .o_clk(o_clk), .o_rst(o_rst), .dout(dout), .dvalid(dvalid),
    .dready(dready), .level(level), .ovf(ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frames enter the scoreboard when the stimulus completes one.
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mlev = 0; mch = 0; movf = 1'b0; masm = '0;
      q.delete();
    end else begin
      automatic logic pop_m = (mlev != 0) && dready;
      automatic int   s = mch;
      automatic frm_t f;
      if (newin) begin
`ifdef AUDIO_BUS_SYNC_EN
        if (sof) begin
          if (mch != 0) movf = 1'b1;
          s = 0;
        end
`endif
        f = masm;
        f[s] = din;
        masm = f;
        if (s == NCH - 1) begin
          mch = 0;
          if (mlev < DEPTH || pop_m) begin
            q.push_back(f);
            mlev++;
          end else movf = 1'b1;
        end else mch = s + 1;
      end
      if (pop_m) mlev--;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("level", 64'(level), 64'(mlev));
      chk("ovf", 64'(ovf), 64'(movf));
      chk("dvalid", 64'(dvalid), 64'(mlev != 0));
      chk("o_clk", 64'(o_clk), 64'(i_clk));
      if (dvalid && dready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pop_frame: got %0h expected none", dout);
        end else chk("pop_frame", dout, q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    newin = 1'b1;
    din   = d;
    #1;
    chk("rinc", 64'(rinc), 64'(1));
    @(posedge i_clk);
    #1;
    newin = 1'b0;
  endtask

  task automatic rst_pulse();
    i_rst = 1'b0;
    cyc();
    i_rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_o_rst", 64'(o_rst), 64'(0));
    chk("rst_dout", dout, 64'(0));
    chk("rst_dvalid", 64'(dvalid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_rinc", 64'(rinc), 64'(0));
    cyc();
    i_rst = 1'b1;
    #1;
    chk("o_rst_hi", 64'(o_rst), 64'(1));
    cyc();

    // First frame latency and channel placement
    dready = 1'b1;
    send(32'hA);
    chk("lat_dvalid_early", 64'(dvalid), 64'(0));
    send(32'hB);
    chk("lat_dvalid", 64'(dvalid), 64'(1));
    chk("lat_dout", dout, 64'h0000000B_0000000A);
    repeat (2) cyc();

    // Overflow: five frames into a stalled four-deep FIFO
    dready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h100 + 32'(i));
    chk("ovf_level", 64'(level), 64'(4));
    chk("ovf_flag", 64'(ovf), 64'(1));
    chk("ovf_head", dout, 64'h00000101_00000100);
    repeat (2) cyc();
    chk("stall_hold", dout, 64'h00000101_00000100);
    dready = 1'b1;
    repeat (6) cyc();
    chk("ovf_drain_sb", 64'(q.size()), 64'(0));
    chk("ovf_drain_level", 64'(level), 64'(0));
    chk("ovf_sticky", 64'(ovf), 64'(1));
    chk("ovf_drain_dvalid", 64'(dvalid), 64'(0));

    // Full FIFO with pop and frame completion on the same edge
    rst_pulse();
    chk("rst_clears_ovf", 64'(ovf), 64'(0));
    dready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h200 + 32'(i));
    chk("full_level", 64'(level), 64'(4));
    send(32'h210);
    dready = 1'b1;
    send(32'h211);
    dready = 1'b0;
    chk("simul_level", 64'(level), 64'(4));
    chk("simul_ovf", 64'(ovf), 64'(0));
    chk("simul_head", dout, 64'h00000203_00000202);
    dready = 1'b1;
    repeat (7) cyc();
    chk("simul_drain_sb", 64'(q.size()), 64'(0));
    chk("simul_drain_level", 64'(level), 64'(0));

    // Reset in the middle of a frame
    send(32'h55);
    i_rst = 1'b0;
    #1;
    chk("mid_o_rst", 64'(o_rst), 64'(0));
    chk("mid_dvalid", 64'(dvalid), 64'(0));
    cyc();
    i_rst = 1'b1;
    cyc();
    send(32'h1);
    send(32'h2);
    chk("mid_dvalid_new", 64'(dvalid), 64'(1));
    chk("mid_dout", dout, 64'h00000002_00000001);
    repeat (2) cyc();

`ifdef AUDIO_BUS_SYNC_EN
    // Start-of-frame on the second sample realigns and flags a framing error
    rst_pulse();
    send(32'h7);
    sof = 1'b1;
    send(32'h8);
    sof = 1'b0;
    chk("sync_ovf", 64'(ovf), 64'(1));
    chk("sync_no_frame", 64'(dvalid), 64'(0));
    send(32'h9);
    chk("sync_dvalid", 64'(dvalid), 64'(1));
    chk("sync_dout", dout, 64'h00000009_00000008);
    repeat (2) cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
